// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared types for the SLC-3 memory arbiter.
// FSM states, requester ownership and counter sizing.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_LD
  } owner_t;

  localparam int CNT_W = 3;

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// Requester-side memory port: req/ack handshake plus
// address, write data and read-back data.
interface mem_arbiter_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );

endinterface

// File: rtl/mem_arbiter_ctrl_load_reg.sv
// Loadable register with synchronous active-high clear.
// Holds its value until load is asserted.
module load_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Shares one synchronous RAM port between loader and CPU,
// hides RAM read latency and decodes the switch/hex I/O address.
module mem_arbiter_ctrl
  import mem_arb_pkg::*;
#(
  parameter int              DATA_W  = 16,
  parameter int              ADDR_W  = 16,
  parameter int              RD_LAT  = 1,
  parameter logic [ADDR_W-1:0] IO_ADDR = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_ctrl_if.slave cpu,
  mem_arbiter_ctrl_if.slave ld,
  output logic              ram_ena,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [DATA_W-1:0] sw_i,
  output logic [DATA_W-1:0] hex_o,
  output logic              busy_o
);

  state_t state;
  state_t state_d;
  owner_t owner;
  owner_t owner_d;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;

  logic [DATA_W-1:0] cpu_rdata;
  logic [DATA_W-1:0] ld_rdata;

  logic              grant;
  logic              io_hit;
  logic              in_access;
  logic              rd_cap;
  logic [DATA_W-1:0] rd_val;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              hex_load;

  assign io_hit    = (lat_addr == IO_ADDR);
  assign in_access = (state == ACCESS);

  // Loader has strict priority over the CPU.
  assign req_we    = ld.req ? ld.we    : cpu.we;
  assign req_addr  = ld.req ? ld.addr  : cpu.addr;
  assign req_wdata = ld.req ? ld.wdata : cpu.wdata;

  always_comb begin
    state_d = state;
    owner_d = owner;
    cnt_d   = cnt;
    grant   = 1'b0;
    rd_cap  = 1'b0;
    rd_val  = ram_rdata;
    unique case (state)
      IDLE: begin
        if (ld.req || cpu.req) begin
          grant   = 1'b1;
          owner_d = ld.req ? OWN_LD : OWN_CPU;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (io_hit) begin
          state_d = DONE;
          if (!lat_we) begin
            rd_cap = 1'b1;
            rd_val = sw_i;
          end
        end else if (lat_we) begin
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          rd_cap  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      cnt   <= cnt_d;
      if (grant) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (rd_cap) begin
        if (owner == OWN_LD) begin
          ld_rdata <= rd_val;
        end else begin
          cpu_rdata <= rd_val;
        end
      end
    end
  end

  // Latched bus values reach the RAM pins only during a RAM access.
  assign ram_ena   = in_access && !io_hit;
  assign ram_we    = ram_ena && lat_we;
  assign ram_addr  = ram_ena ? lat_addr  : '0;
  assign ram_wdata = ram_ena ? lat_wdata : '0;

  assign cpu.rdata = cpu_rdata;
  assign ld.rdata  = ld_rdata;
  assign cpu.ack   = (state == DONE) && (owner == OWN_CPU);
  assign ld.ack    = (state == DONE) && (owner == OWN_LD);
  assign busy_o    = (state != IDLE);

  assign hex_load = in_access && io_hit && lat_we;

  load_reg #(
    .W(DATA_W)
  ) u_hex (
    .clk  (clk),
    .reset(reset),
    .load (hex_load),
    .d    (lat_wdata),
    .q    (hex_o)
  );

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench: four arbiter instances with read latencies
// 1, 2, 3 and 7, each behind its own behavioural RAM.
module tb_mem_arbiter_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        rst      [4];
  logic        cpu_req  [4];
  logic        cpu_we   [4];
  logic [15:0] cpu_addr [4];
  logic [15:0] cpu_wd   [4];
  logic        ld_req   [4];
  logic        ld_we    [4];
  logic [15:0] ld_addr  [4];
  logic [15:0] ld_wd    [4];
  logic [15:0] sw;

  wire  [15:0] cpu_rd   [4];
  wire  [15:0] ld_rd    [4];
  wire         cpu_ack  [4];
  wire         ld_ack   [4];
  wire         ram_ena  [4];
  wire         ram_we   [4];
  wire  [15:0] ram_addr [4];
  wire  [15:0] ram_wd   [4];
  wire  [15:0] ram_rd   [4];
  wire  [15:0] hex      [4];
  wire         busy     [4];

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 7;

    mem_arbiter_ctrl_if #(.DATA_W(16), .ADDR_W(16)) cpu_b ();
    mem_arbiter_ctrl_if #(.DATA_W(16), .ADDR_W(16)) ld_b ();

    assign cpu_b.req   = cpu_req[g];
    assign cpu_b.we    = cpu_we[g];
    assign cpu_b.addr  = cpu_addr[g];
    assign cpu_b.wdata = cpu_wd[g];
    assign cpu_rd[g]   = cpu_b.rdata;
    assign cpu_ack[g]  = cpu_b.ack;
    assign ld_b.req    = ld_req[g];
    assign ld_b.we     = ld_we[g];
    assign ld_b.addr   = ld_addr[g];
    assign ld_b.wdata  = ld_wd[g];
    assign ld_rd[g]    = ld_b.rdata;
    assign ld_ack[g]   = ld_b.ack;

    logic [15:0] mem  [256];
    logic [15:0] pipe [L];

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[16] = 16'h1234;
    end

    always @(posedge clk) begin
      if (ram_ena[g] && ram_we[g]) mem[ram_addr[g][7:0]] <= ram_wd[g];
      pipe[0] <= mem[ram_addr[g][7:0]];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    assign ram_rd[g] = pipe[L-1];

    mem_arbiter_ctrl #(
      .DATA_W (16),
      .ADDR_W (16),
      .RD_LAT (L),
      .IO_ADDR(16'hFFFF)
    ) dut (
      .clk      (clk),
      .reset    (rst[g]),
      .cpu      (cpu_b.slave),
      .ld       (ld_b.slave),
      .ram_ena  (ram_ena[g]),
      .ram_we   (ram_we[g]),
      .ram_addr (ram_addr[g]),
      .ram_wdata(ram_wd[g]),
      .ram_rdata(ram_rd[g]),
      .sw_i     (sw),
      .hex_o    (hex[g]),
      .busy_o   (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int k);
    @(negedge clk);
    for (int i = 0; i < 20 && busy[k]; i++) @(negedge clk);
  endtask

  // Issues one transaction; cycle 1 is the cycle after the sampling IDLE.
  task automatic txn(input int k, input bit isld, input bit we,
                     input logic [15:0] a, input logic [15:0] d,
                     output int ack_c, output int ena_n,
                     output int ena_f, output int oth);
    ack_c = -1; ena_n = 0; ena_f = -1; oth = 0;
    wait_idle(k);
    if (isld) begin
      ld_req[k] = 1'b1; ld_we[k] = we; ld_addr[k] = a; ld_wd[k] = d;
    end else begin
      cpu_req[k] = 1'b1; cpu_we[k] = we; cpu_addr[k] = a; cpu_wd[k] = d;
    end
    for (int c = 1; c <= 20 && ack_c < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        if (isld) begin ld_addr[k] = ~a; ld_wd[k] = ~d; end
        else begin cpu_addr[k] = ~a; cpu_wd[k] = ~d; end
      end
      if (ram_ena[k]) begin
        ena_n++;
        if (ena_f < 0) ena_f = c;
      end
      if (isld ? cpu_ack[k] : ld_ack[k]) oth = 1;
      if (isld ? ld_ack[k] : cpu_ack[k]) begin
        ack_c = c;
        if (isld) ld_req[k] = 1'b0; else cpu_req[k] = 1'b0;
      end
    end
    if (isld) ld_req[k] = 1'b0; else cpu_req[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ac, en, ef, ot, lc, cc, ov, nack;

    sw = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1;
      cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wd[k] = '0;
      ld_req[k]  = 1'b0; ld_we[k]  = 1'b0; ld_addr[k]  = '0; ld_wd[k]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   32'(busy[0]),    32'h0);
    chk("rst_ena",    32'(ram_ena[0]), 32'h0);
    chk("rst_addr",   32'(ram_addr[0]), 32'h0);
    chk("rst_cack",   32'(cpu_ack[0]), 32'h0);
    chk("rst_lack",   32'(ld_ack[0]),  32'h0);
    chk("rst_hex",    32'(hex[0]),     32'h0);
    chk("rst_crd",    32'(cpu_rd[0]),  32'h0);
    chk("rst_lrd",    32'(ld_rd[0]),   32'h0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;

    // 1: CPU RAM read, RD_LAT=1
    txn(0, 1'b0, 1'b0, 16'h0010, 16'h0000, ac, en, ef, ot);
    chk("t1_ack_cyc", 32'(ac), 32'd3);
    chk("t1_rdata",   32'(cpu_rd[0]), 32'h1234);
    chk("t1_ena_n",   32'(en), 32'd1);
    chk("t1_ena_cyc", 32'(ef), 32'd1);
    chk("t1_ld_ack",  32'(ot), 32'd0);

    // 2: write then read back
    txn(0, 1'b0, 1'b1, 16'h0020, 16'hBEEF, ac, en, ef, ot);
    chk("t2_wr_ack",   32'(ac), 32'd2);
    chk("t2_wr_keep",  32'(cpu_rd[0]), 32'h1234);
    txn(0, 1'b0, 1'b0, 16'h0020, 16'h0000, ac, en, ef, ot);
    chk("t2_rd_ack",   32'(ac), 32'd3);
    chk("t2_rd_data",  32'(cpu_rd[0]), 32'hBEEF);

    // 3: IO read and write
    sw = 16'h00A5;
    txn(0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, ac, en, ef, ot);
    chk("t3_rd_ack",  32'(ac), 32'd2);
    chk("t3_rd_data", 32'(cpu_rd[0]), 32'h00A5);
    chk("t3_rd_ena",  32'(en), 32'd0);
    txn(0, 1'b0, 1'b1, 16'hFFFF, 16'h3C3C, ac, en, ef, ot);
    chk("t3_wr_ack",  32'(ac), 32'd2);
    chk("t3_wr_ena",  32'(en), 32'd0);
    @(posedge clk); #1;
    chk("t3_hex",     32'(hex[0]), 32'h3C3C);
    chk("t3_rd_keep", 32'(cpu_rd[0]), 32'h00A5);

    // 4: simultaneous loader write and CPU read
    wait_idle(0);
    ld_req[0] = 1'b1; ld_we[0] = 1'b1; ld_addr[0] = 16'h0000;
    ld_wd[0] = 16'h0001;
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 16'h0000;
    lc = -1; cc = -1; ov = 0;
    for (int c = 1; c <= 20 && cc < 0; c++) begin
      @(posedge clk); #1;
      if (ld_ack[0] && cpu_ack[0]) ov = 1;
      if (ld_ack[0]) begin lc = c; ld_req[0] = 1'b0; end
      if (cpu_ack[0]) begin cc = c; cpu_req[0] = 1'b0; end
    end
    ld_req[0] = 1'b0; cpu_req[0] = 1'b0;
    chk("t4_ld_ack",  32'(lc), 32'd2);
    chk("t4_cpu_ack", 32'(cc), 32'd6);
    chk("t4_rdata",   32'(cpu_rd[0]), 32'h0001);
    chk("t4_overlap", 32'(ov), 32'd0);

    // 5: reset during WAIT, RD_LAT=3
    txn(2, 1'b0, 1'b0, 16'hFFFF, 16'h0000, ac, en, ef, ot);
    chk("t5_io_rd",   32'(cpu_rd[2]), 32'h00A5);
    txn(2, 1'b0, 1'b1, 16'hFFFF, 16'h5A5A, ac, en, ef, ot);
    @(posedge clk); #1;
    chk("t5_hex_pre", 32'(hex[2]), 32'h5A5A);
    wait_idle(2);
    cpu_req[2] = 1'b1; cpu_we[2] = 1'b0; cpu_addr[2] = 16'h0010;
    nack = 0;
    @(posedge clk); #1;
    chk("t5_ena_c1", 32'(ram_ena[2]), 32'h1);
    @(posedge clk); #1;
    if (cpu_ack[2]) nack++;
    @(posedge clk); #1;
    if (cpu_ack[2]) nack++;
    chk("t5_busy_wait", 32'(busy[2]), 32'h1);
    rst[2] = 1'b1;
    @(posedge clk); #1;
    chk("t5_busy", 32'(busy[2]),    32'h0);
    chk("t5_cack", 32'(cpu_ack[2]), 32'h0);
    chk("t5_ena",  32'(ram_ena[2]), 32'h0);
    chk("t5_hex",  32'(hex[2]),     32'h0);
    chk("t5_crd",  32'(cpu_rd[2]),  32'h0);
    cpu_req[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (cpu_ack[2] || ld_ack[2]) nack++;
    end
    chk("t5_no_ack", 32'(nack), 32'd0);

    // 6: latency sweep
    txn(1, 1'b0, 1'b0, 16'h0010, 16'h0000, ac, en, ef, ot);
    chk("t6_l2_ack",  32'(ac), 32'd4);
    chk("t6_l2_data", 32'(cpu_rd[1]), 32'h1234);
    txn(3, 1'b0, 1'b0, 16'h0010, 16'h0000, ac, en, ef, ot);
    chk("t6_l7_ack",  32'(ac), 32'd9);
    chk("t6_l7_data", 32'(cpu_rd[3]), 32'h1234);
    chk("t6_l7_ena",  32'(en), 32'd1);

    // loader read uses its own rdata register
    txn(0, 1'b1, 1'b0, 16'h0020, 16'h0000, ac, en, ef, ot);
    chk("t7_ld_ack",  32'(ac), 32'd3);
    chk("t7_ld_data", 32'(ld_rd[0]), 32'hBEEF);
    chk("t7_cpu_keep", 32'(cpu_rd[0]), 32'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
